// File: rtl/exc_arbiter.sv
// MEM-stage exception arbiter: picks the highest-priority cause, waits for data-bus drain, then issues a one-cycle CP0 commit plus flush/redirect.
// Optional drain watchdog enabled by defining EXC_DRAIN_TIMEOUT_EN; otherwise drain_timeout_o is tied low.
module exc_arbiter #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_in_delayslot,
  input  logic [7:0]  mem_exc_flags,
  input  logic [31:0] mem_bad_addr,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  input  logic        bus_busy,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        stall_o,
  output logic        drain_timeout_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        int_pending;
  logic        take_event;
  logic        capture;
  logic        timeout_hit;
  logic [7:0]  code_sel;
  logic [7:0]  code_q;
  logic [7:0]  commit_code;
  logic [31:0] bad_sel;
  logic [31:0] new_pc_sel;

  // Only the IE/EXL/IM fields of status and the IP field of cause matter here.
  logic unused_cp0_bits;
  assign unused_cp0_bits = ^{cp0_status[31:16], cp0_status[7:2],
                             cp0_cause[31:16], cp0_cause[7:0]};

  // Cause selection, highest priority first; eret loses to every real fault.
  always_comb begin
    int_pending = cp0_status[0] & ~cp0_status[1] &
                  (|(cp0_cause[15:8] & cp0_status[15:8]));
    code_sel    = 8'h00;
    bad_sel     = 32'h0;
    if (int_pending) begin
      code_sel = 8'h01;
    end else if (mem_exc_flags[0]) begin
      code_sel = 8'h04;
      bad_sel  = mem_pc;
    end else if (mem_exc_flags[1]) begin
      code_sel = 8'h0a;
    end else if (mem_exc_flags[2]) begin
      code_sel = 8'h0c;
    end else if (mem_exc_flags[3]) begin
      code_sel = 8'h08;
    end else if (mem_exc_flags[4]) begin
      code_sel = 8'h09;
    end else if (mem_exc_flags[6]) begin
      code_sel = 8'h04;
      bad_sel  = mem_bad_addr;
    end else if (mem_exc_flags[7]) begin
      code_sel = 8'h05;
      bad_sel  = mem_bad_addr;
    end else if (mem_exc_flags[5]) begin
      code_sel = 8'h0e;
    end
    take_event = mem_valid & (int_pending | (|mem_exc_flags));
    new_pc_sel = (code_sel == 8'h0e) ? cp0_epc : EXC_VECTOR;
  end

`ifdef EXC_DRAIN_TIMEOUT_EN
  logic [7:0] drain_cnt;
`endif

  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (take_event) state_nxt = bus_busy ? DRAIN : COMMIT;
      end
      DRAIN: begin
        if (!bus_busy) begin
          state_nxt = COMMIT;
`ifdef EXC_DRAIN_TIMEOUT_EN
        end else if (drain_cnt == 8'hff) begin
          state_nxt   = COMMIT;
          timeout_hit = 1'b1;
`endif
        end
      end
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign capture     = (state == IDLE) && take_event;
  assign commit_code = capture ? code_sel : code_q;

  // Outputs are computed from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      code_q              <= 8'h00;
      current_inst_addr_o <= 32'h0;
      is_in_delayslot_o   <= 1'b0;
      bad_addr_o          <= 32'h0;
      new_pc_o            <= 32'h0;
      excepttype_o        <= 32'h0;
      flush_o             <= 1'b0;
      stall_o             <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        code_q              <= code_sel;
        current_inst_addr_o <= mem_pc;
        is_in_delayslot_o   <= mem_in_delayslot;
        bad_addr_o          <= bad_sel;
        new_pc_o            <= new_pc_sel;
      end
      excepttype_o <= (state_nxt == COMMIT) ? {24'h0, commit_code} : 32'h0;
      flush_o      <= (state_nxt == COMMIT);
      stall_o      <= (state_nxt == DRAIN);
    end
  end

`ifdef EXC_DRAIN_TIMEOUT_EN
  // Counter is held at zero outside DRAIN, so every DRAIN visit starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_cnt       <= 8'h00;
      drain_timeout_o <= 1'b0;
    end else begin
      drain_cnt       <= (state_nxt == DRAIN && state == DRAIN) ? drain_cnt + 8'h01 : 8'h00;
      drain_timeout_o <= drain_timeout_o | timeout_hit;
    end
  end
`else
  assign drain_timeout_o = 1'b0;
  logic unused_timeout;
  assign unused_timeout = timeout_hit;
`endif

endmodule

// File: tb/tb_exc_arbiter.sv
// Directed bench for exc_arbiter: reset, priority, drain, eret, back-to-back, reset-in-drain, watchdog.
module tb_exc_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_in_delayslot;
  logic [7:0]  mem_exc_flags;
  logic [31:0] mem_bad_addr;
  logic [31:0] cp0_status;
  logic [31:0] cp0_cause;
  logic [31:0] cp0_epc;
  logic        bus_busy;
  logic [31:0] excepttype_o;
  logic [31:0] current_inst_addr_o;
  logic        is_in_delayslot_o;
  logic [31:0] bad_addr_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        stall_o;
  logic        drain_timeout_o;

  int checks = 0;
  int errors = 0;

  exc_arbiter dut (
    .clk                 (clk),
    .rst                 (rst),
    .mem_valid           (mem_valid),
    .mem_pc              (mem_pc),
    .mem_in_delayslot    (mem_in_delayslot),
    .mem_exc_flags       (mem_exc_flags),
    .mem_bad_addr        (mem_bad_addr),
    .cp0_status          (cp0_status),
    .cp0_cause           (cp0_cause),
    .cp0_epc             (cp0_epc),
    .bus_busy            (bus_busy),
    .excepttype_o        (excepttype_o),
    .current_inst_addr_o (current_inst_addr_o),
    .is_in_delayslot_o   (is_in_delayslot_o),
    .bad_addr_o          (bad_addr_o),
    .flush_o             (flush_o),
    .new_pc_o            (new_pc_o),
    .stall_o             (stall_o),
    .drain_timeout_o     (drain_timeout_o)
  );

  always #5 clk = ~clk;

  task automatic set_quiet();
    mem_valid        = 1'b0;
    mem_pc           = 32'h0;
    mem_in_delayslot = 1'b0;
    mem_exc_flags    = 8'h00;
    mem_bad_addr     = 32'h0;
    cp0_status       = 32'h0;
    cp0_cause        = 32'h0;
    cp0_epc          = 32'h0;
    bus_busy         = 1'b0;
  endtask

  task automatic test_reset();
    set_quiet();
    rst = 1'b1;
    #2;
    checks++;
    if ({excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o, flush_o,
         new_pc_o, stall_o, drain_timeout_o} !== 164'h0) begin
      errors++;
      $display("FAIL reset_outputs: got exc=%h pc=%h flush=%b stall=%b want all 0",
               excepttype_o, current_inst_addr_o, flush_o, stall_o);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_ov();
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_exc_flags = 8'h04; mem_pc = 32'hBFC00100;
    @(posedge clk); #1 mem_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (excepttype_o !== 32'h0c || current_inst_addr_o !== 32'hBFC00100 ||
        flush_o !== 1'b1 || new_pc_o !== 32'hBFC00380 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL ov_commit: got exc=%h pc=%h flush=%b npc=%h stall=%b want 0c bfc00100 1 bfc00380 0",
               excepttype_o, current_inst_addr_o, flush_o, new_pc_o, stall_o);
    end
    @(negedge clk);
    checks++;
    if (flush_o !== 1'b0 || excepttype_o !== 32'h0) begin
      errors++;
      $display("FAIL ov_one_cycle: got flush=%b exc=%h want 0 0", flush_o, excepttype_o);
    end
  endtask

  task automatic test_interrupt_priority();
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_exc_flags = 8'h20; mem_pc = 32'h8000_0040;
    cp0_status = 32'h0000_0401; cp0_cause = 32'h0000_0400; cp0_epc = 32'h1234_5678;
    @(posedge clk); #1 set_quiet();
    @(negedge clk);
    checks++;
    if (excepttype_o !== 32'h01 || new_pc_o !== 32'hBFC00380 || flush_o !== 1'b1) begin
      errors++;
      $display("FAIL int_priority: got exc=%h npc=%h flush=%b want 01 bfc00380 1",
               excepttype_o, new_pc_o, flush_o);
    end
  endtask

  task automatic test_priority_table();
    logic [7:0]  flags [8] = '{8'h03, 8'h06, 8'h0c, 8'h18, 8'h30, 8'he0, 8'ha0, 8'h20};
    logic [7:0]  codes [8] = '{8'h04, 8'h0a, 8'h0c, 8'h08, 8'h09, 8'h04, 8'h05, 8'h0e};
    logic [31:0] want_bad;
    logic [31:0] want_npc;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      mem_valid = 1'b1; mem_exc_flags = flags[i];
      mem_pc = 32'h1000_0000 + i; mem_bad_addr = 32'h2000_0000 + i;
      cp0_epc = 32'h8000_0180;
      want_bad = (i == 0) ? 32'h1000_0000 : ((i == 5 || i == 6) ? 32'h2000_0000 + i : 32'h0);
      want_npc = (i == 7) ? 32'h8000_0180 : 32'hBFC00380;
      @(posedge clk); #1 set_quiet();
      @(negedge clk);
      checks++;
      if (excepttype_o !== {24'h0, codes[i]} || bad_addr_o !== want_bad ||
          new_pc_o !== want_npc || flush_o !== 1'b1) begin
        errors++;
        $display("FAIL prio_%0d: got exc=%h bad=%h npc=%h flush=%b want %h %h %h 1",
                 i, excepttype_o, bad_addr_o, new_pc_o, flush_o, codes[i], want_bad, want_npc);
      end
    end
  endtask

  task automatic test_drain();
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_exc_flags = 8'h80; mem_bad_addr = 32'h80001002;
    mem_pc = 32'h8000_0100; bus_busy = 1'b1;
    @(posedge clk); #1 mem_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (stall_o !== 1'b1 || flush_o !== 1'b0 || excepttype_o !== 32'h0) begin
        errors++;
        $display("FAIL drain_stall_%0d: got stall=%b flush=%b exc=%h want 1 0 0",
                 i, stall_o, flush_o, excepttype_o);
      end
      if (i == 4) bus_busy = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (stall_o !== 1'b0 || flush_o !== 1'b1 || excepttype_o !== 32'h05 ||
        bad_addr_o !== 32'h80001002) begin
      errors++;
      $display("FAIL drain_commit: got stall=%b flush=%b exc=%h bad=%h want 0 1 05 80001002",
               stall_o, flush_o, excepttype_o, bad_addr_o);
    end
    @(negedge clk);
    checks++;
    if (flush_o !== 1'b0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_after: got flush=%b stall=%b want 0 0", flush_o, stall_o);
    end
  endtask

  task automatic test_eret_delayslot();
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_exc_flags = 8'h20; cp0_epc = 32'hBFC00200;
    mem_in_delayslot = 1'b1; mem_pc = 32'hBFC00104;
    @(posedge clk); #1 set_quiet();
    @(negedge clk);
    checks++;
    if (excepttype_o !== 32'h0e || new_pc_o !== 32'hBFC00200 || is_in_delayslot_o !== 1'b1 ||
        current_inst_addr_o !== 32'hBFC00104 || bad_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL eret_ds: got exc=%h npc=%h ds=%b pc=%h bad=%h want 0e bfc00200 1 bfc00104 0",
               excepttype_o, new_pc_o, is_in_delayslot_o, current_inst_addr_o, bad_addr_o);
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_exc_flags = 8'h08; mem_pc = 32'h0000_1000;
    @(posedge clk); #1;
    mem_exc_flags = 8'h10; mem_pc = 32'h0000_2000;
    @(negedge clk);
    checks++;
    if (excepttype_o !== 32'h08 || current_inst_addr_o !== 32'h0000_1000 || flush_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: got exc=%h pc=%h flush=%b want 08 00001000 1",
               excepttype_o, current_inst_addr_o, flush_o);
    end
    @(negedge clk);
    checks++;
    if (flush_o !== 1'b0 || excepttype_o !== 32'h0) begin
      errors++;
      $display("FAIL b2b_gap: got flush=%b exc=%h want 0 0", flush_o, excepttype_o);
    end
    @(posedge clk); #1 set_quiet();
    @(negedge clk);
    checks++;
    if (excepttype_o !== 32'h09 || current_inst_addr_o !== 32'h0000_2000 || flush_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: got exc=%h pc=%h flush=%b want 09 00002000 1",
               excepttype_o, current_inst_addr_o, flush_o);
    end
  endtask

  task automatic test_reset_in_drain();
    int flushes = 0;
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_exc_flags = 8'h02; mem_pc = 32'h0000_3000; bus_busy = 1'b1;
    @(posedge clk); #1 mem_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (stall_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_drain_enter: got stall=%b want 1", stall_o);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o, flush_o,
         new_pc_o, stall_o, drain_timeout_o} !== 164'h0) begin
      errors++;
      $display("FAIL rst_drain_outputs: got exc=%h pc=%h stall=%b flush=%b want all 0",
               excepttype_o, current_inst_addr_o, stall_o, flush_o);
    end
    bus_busy = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (flush_o !== 1'b0 || stall_o !== 1'b0) flushes++;
    end
    checks++;
    if (flushes != 0) begin
      errors++;
      $display("FAIL rst_drain_no_commit: got %0d active cycles want 0", flushes);
    end
  endtask

  task automatic test_no_valid_interrupt();
    int active = 0;
    @(posedge clk); #1;
    mem_valid = 1'b0; cp0_status = 32'h0000_0401; cp0_cause = 32'h0000_0400;
    mem_exc_flags = 8'h04;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (flush_o !== 1'b0 || stall_o !== 1'b0 || excepttype_o !== 32'h0) active++;
    end
    checks++;
    if (active != 0) begin
      errors++;
      $display("FAIL novalid_int: got %0d active cycles want 0", active);
    end
    set_quiet();
  endtask

  task automatic test_drain_watchdog();
    int bad_stall = 0;
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_exc_flags = 8'h01; mem_pc = 32'h0000_4000; bus_busy = 1'b1;
    @(posedge clk); #1 mem_valid = 1'b0;
`ifdef EXC_DRAIN_TIMEOUT_EN
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (stall_o !== 1'b1 || flush_o !== 1'b0) bad_stall++;
    end
    checks++;
    if (bad_stall != 0) begin
      errors++;
      $display("FAIL wd_stall: got %0d non-stall cycles want 0", bad_stall);
    end
    @(negedge clk);
    checks++;
    if (flush_o !== 1'b1 || excepttype_o !== 32'h04 || drain_timeout_o !== 1'b1 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL wd_commit: got flush=%b exc=%h to=%b stall=%b want 1 04 1 0",
               flush_o, excepttype_o, drain_timeout_o, stall_o);
    end
    bus_busy = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (drain_timeout_o !== 1'b1 || flush_o !== 1'b0) begin
      errors++;
      $display("FAIL wd_sticky: got to=%b flush=%b want 1 0", drain_timeout_o, flush_o);
    end
`else
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (stall_o !== 1'b1 || flush_o !== 1'b0 || drain_timeout_o !== 1'b0) bad_stall++;
    end
    checks++;
    if (bad_stall != 0) begin
      errors++;
      $display("FAIL wd_off_wait: got %0d bad cycles want 0", bad_stall);
    end
    bus_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (flush_o !== 1'b1 || excepttype_o !== 32'h04 || drain_timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL wd_off_commit: got flush=%b exc=%h to=%b want 1 04 0",
               flush_o, excepttype_o, drain_timeout_o);
    end
`endif
    set_quiet();
  endtask

  initial begin
    test_reset();
    test_ov();
    test_interrupt_priority();
    test_priority_table();
    test_drain();
    test_eret_delayslot();
    test_back_to_back();
    test_no_valid_interrupt();
    test_drain_watchdog();
    test_reset_in_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exc_arbiter.md
# exc_arbiter

MEM-stage exception arbiter and flush sequencer. It evaluates the per-instruction exception flags and pending interrupts, and picks the highest-priority cause. It then waits for outstanding data-bus traffic to drain and issues a one-cycle commit to cp0_reg (excepttype, PC, delay-slot, bad address) together with a pipeline flush and redirect PC. It sits between the MEM stage and cp0_reg / PC-select logic.

## Interface
- EXC_VECTOR, 32'hBFC00380, redirect target for all exceptions except eret
- clk  in  1  clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- mem_valid  in  1  MEM holds a real (non-bubble) instruction
- mem_pc  in  32  PC of the MEM instruction
- mem_in_delayslot  in  1  MEM instruction is in a delay slot
- mem_exc_flags  in  8  [0] fetch AdEL, [1] RI, [2] Ov, [3] syscall, [4] break, [5] eret, [6] load AdEL, [7] store AdES
- mem_bad_addr  in  32  data address of the MEM load/store
- cp0_status, cp0_cause, cp0_epc  in  32 each  live CP0 values
- bus_busy  in  1  data-side AXI transaction outstanding
- excepttype_o  out  32  cause code to cp0_reg, nonzero only in COMMIT
- current_inst_addr_o  out  32  latched mem_pc
- is_in_delayslot_o  out  1  latched delay-slot flag
- bad_addr_o  out  32  latched faulting address
- flush_o  out  1  pipeline flush, one cycle
- new_pc_o  out  32  redirect PC, valid with flush_o
- stall_o  out  1  freeze pipeline while draining
- drain_timeout_o  out  1  sticky watchdog flag (see Configuration)

## Operation
- Interrupt pending = status[0] & ~status[1] & |(cause[15:8] & status[15:8]).
- Exceptions are considered only when mem_valid=1. With mem_valid=0, no event is taken, even if an interrupt is pending.
- Priority and code, highest first:
  - interrupt 0x01
  - fetch AdEL 0x04
  - RI 0x0a
  - Ov 0x0c
  - syscall 0x08
  - break 0x09
  - load AdEL 0x04
  - store AdES 0x05
  - eret 0x0e
- bad_addr: mem_pc for fetch AdEL; mem_bad_addr for data AdEL/AdES; 0 otherwise.
- new_pc: cp0_epc, sampled at capture, when the code is 0x0e; EXC_VECTOR otherwise.
- FSM states:
  - IDLE: on an event, latch code, PC, delay-slot flag, bad_addr and new_pc. Go to DRAIN if bus_busy, else COMMIT.
  - DRAIN: stall_o=1; inputs ignored. Go to COMMIT on the first cycle bus_busy=0.
  - COMMIT: excepttype_o = latched code, flush_o=1; inputs ignored. Go to IDLE.
- All outputs are registered.
- Reset values: all outputs 0, state IDLE, latches 0.

## Timing
- Event sampled in cycle N, bus idle: COMMIT in N+1. flush_o and excepttype_o are high for exactly that one cycle, then return to 0.
- Bus busy: stall_o is high from N+1 until the cycle before COMMIT. COMMIT follows one cycle after bus_busy is first seen low in DRAIN.
- cp0_reg samples excepttype_o on negedge inside the COMMIT cycle.
- Back-to-back: an event in the cycle after COMMIT (in IDLE) is accepted normally.
- Reset asserted in DRAIN or COMMIT: immediate return to IDLE; no commit issued; flush_o drops asynchronously.

## Configuration
- EXC_DRAIN_TIMEOUT_EN defined: an 8-bit counter runs in DRAIN, cleared on entry. When it reaches 255 with bus_busy still 1, the FSM goes to COMMIT anyway and sets drain_timeout_o. The flag stays set until reset.
- EXC_DRAIN_TIMEOUT_EN undefined: DRAIN waits indefinitely, and drain_timeout_o is tied 0.

## Test plan
- mem_valid=1, flags=0x04 (Ov), mem_pc=0xBFC00100, bus idle -> next cycle: excepttype_o=0x0c, current_inst_addr_o=0xBFC00100, flush_o=1, new_pc_o=0xBFC00380 for one cycle.
- status=0x00000401, cause[10]=1, flags=0x20 (eret) -> interrupt wins: excepttype_o=0x01, new_pc_o=EXC_VECTOR.
- flags=0x80, mem_bad_addr=0x80001002, bus_busy=1 for 5 cycles -> stall_o high 5 cycles, then COMMIT: excepttype_o=0x05, bad_addr_o=0x80001002.
- eret alone, cp0_epc=0xBFC00200, mem_in_delayslot=1 -> excepttype_o=0x0e, new_pc_o=0xBFC00200, is_in_delayslot_o=1.
- Reset pulse during DRAIN -> no flush_o, all outputs 0; mem_valid=0 with a pending interrupt -> no event.
- With EXC_DRAIN_TIMEOUT_EN, bus_busy stuck at 1 -> COMMIT 256 cycles after DRAIN entry, drain_timeout_o=1 and sticky.
